// File: rtl/xlr8_rng_buf.sv
// xlr8_rng_buf: small byte FIFO that buffers values taken from an upstream
// LFSR and exposes them through a status/control register and a data
// register on the data-memory bus.
// Optional feature macro: XLR8_RNG_WHITEN_EN (XOR each captured byte with the
// rotated previous raw capture before storing it).
module xlr8_rng_buf #(
    parameter logic [7:0] RNG_CTRL_ADDR = 8'h00,
    parameter logic [7:0] RNG_DATA_ADDR = 8'h00,
    parameter int         DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [7:0] dbus_in,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] lfsr_data,
    output logic       lfsr_step
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Fill handshake: IDLE may request a new byte, WAIT captures it next edge
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_WAIT = 1'b1
    } fill_state_t;

    fill_state_t   fill_state;
    logic          en;
    logic          underflow;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    push_byte;

    logic ctrl_sel;
    logic data_sel;
    logic ctrl_re;
    logic ctrl_we;
    logic data_re;
    logic is_empty;
    logic is_full;
    logic push;
    logic pop;
    logic [7:0] status;

    // Only EN and the underflow clear bit of a control write carry meaning
    logic unused_dbus_bits;
    assign unused_dbus_bits = ^{dbus_in[7:4], dbus_in[2:1]};

    assign ctrl_sel = dm_sel && (ramadr == RNG_CTRL_ADDR);
    assign data_sel = dm_sel && (ramadr == RNG_DATA_ADDR);
    assign ctrl_re  = ctrl_sel && ramre;
    assign ctrl_we  = ctrl_sel && ramwe;
    assign data_re  = data_sel && ramre;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_COUNT);

    assign lfsr_step = clken && en && (fill_state == FILL_IDLE) && (count < FULL_COUNT);
    assign push      = clken && (fill_state == FILL_WAIT);
    assign pop       = clken && data_re && !is_empty;

    assign status = {4'(count), underflow, is_full, is_empty, en};

`ifdef XLR8_RNG_WHITEN_EN
    logic [7:0] prev_raw;

    // Whitening history: remembers the last raw LFSR byte that was captured
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw <= 8'h00;
        end else if (push) begin
            prev_raw <= lfsr_data;
        end
    end

    assign push_byte = lfsr_data ^ {prev_raw[0], prev_raw[7:1]};
`else
    assign push_byte = lfsr_data;
`endif

    // Control register, fill handshake, pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            underflow  <= 1'b0;
            fill_state <= FILL_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else if (clken) begin
            if (ctrl_we) begin
                en <= dbus_in[0];
            end

            if (data_re && is_empty) begin
                underflow <= 1'b1;
            end else if (ctrl_we && dbus_in[3]) begin
                underflow <= 1'b0;
            end

            case (fill_state)
                FILL_IDLE: begin
                    if (lfsr_step) begin
                        fill_state <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    fill_state <= FILL_IDLE;
                end
                default: begin
                    fill_state <= FILL_IDLE;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte storage; contents need no reset because COUNT gates every read
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    // Read mux: status has priority, an empty FIFO reads back as zero
    always_comb begin
        dbus_out  = 8'h00;
        io_out_en = ctrl_re || data_re;
        if (ctrl_sel) begin
            dbus_out = status;
        end else if (data_sel && !is_empty) begin
            dbus_out = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_xlr8_rng_buf.sv
// tb_xlr8_rng_buf: randomized and directed self-checking bench for
// xlr8_rng_buf, compared against a queue-based behavioural model.
module tb_xlr8_rng_buf;

    localparam logic [7:0] CTRL_A = 8'h10;
    localparam logic [7:0] DATA_A = 8'h11;
    localparam logic [7:0] IDLE_A = 8'h55;
    localparam int         DEPTH  = 4;

    logic       clk;
    logic       rst;
    logic       clken;
    logic [7:0] dbus_in;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic [7:0] lfsr_data;
    logic       lfsr_step;

    int checks;
    int failures;

    // Behavioural model state
    bit         m_en;
    bit         m_uf;
    bit         m_pend;
    logic [7:0] m_q[$];
    logic [7:0] m_prev;
    logic [7:0] src_q[$];

    xlr8_rng_buf #(
        .RNG_CTRL_ADDR(CTRL_A),
        .RNG_DATA_ADDR(DATA_A),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .dbus_in  (dbus_in),
        .ramadr   (ramadr),
        .ramre    (ramre),
        .ramwe    (ramwe),
        .dm_sel   (dm_sel),
        .dbus_out (dbus_out),
        .io_out_en(io_out_en),
        .lfsr_data(lfsr_data),
        .lfsr_step(lfsr_step)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        int n;
        n = m_q.size();
        return {4'(n), m_uf, (n == DEPTH), (n == 0), m_en};
    endfunction

    function automatic logic exp_step();
        return clken && m_en && !m_pend && (m_q.size() < DEPTH);
    endfunction

    function automatic logic exp_oen();
        return dm_sel && ramre && (ramadr == CTRL_A || ramadr == DATA_A);
    endfunction

    function automatic logic [7:0] exp_dout();
        if (dm_sel && ramadr == CTRL_A) return exp_status();
        if (dm_sel && ramadr == DATA_A && m_q.size() > 0) return m_q[0];
        return 8'h00;
    endfunction

    function automatic logic [7:0] next_src();
        if (src_q.size() > 0) return src_q.pop_front();
        return 8'($urandom);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_update();
        bit         start;
        bit         capture;
        bit         data_rd;
        bit         ctrl_wr;
        logic [7:0] b;
        if (rst) begin
            m_en = 0; m_uf = 0; m_pend = 0; m_prev = 8'h00;
            m_q.delete();
        end else if (clken) begin
            start   = m_en && !m_pend && (m_q.size() < DEPTH);
            capture = m_pend;
            data_rd = dm_sel && ramre && ramadr == DATA_A;
            ctrl_wr = dm_sel && ramwe && ramadr == CTRL_A;
            if (ctrl_wr) begin
                m_en = dbus_in[0];
                if (dbus_in[3]) m_uf = 0;
            end
            if (data_rd) begin
                if (m_q.size() > 0) m_q.delete(0);
                else m_uf = 1;
            end
            if (capture) begin
`ifdef XLR8_RNG_WHITEN_EN
                b = lfsr_data ^ {m_prev[0], m_prev[7:1]};
                m_prev = lfsr_data;
`else
                b = lfsr_data;
`endif
                m_q.push_back(b);
                m_pend = 0;
            end else if (start) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic ce, input logic sel, input logic [7:0] adr,
                         input logic re, input logic we, input logic [7:0] d);
        rst = r; clken = ce; dm_sel = sel; ramadr = adr; ramre = re; ramwe = we; dbus_in = d;
    endtask

    // One clock: update the model, let the edge happen, then the upstream LFSR reacts
    task automatic tick();
        logic stepped;
        stepped = lfsr_step;
        model_update();
        @(posedge clk);
        #1;
        if (stepped) lfsr_data = next_src();
    endtask

    task automatic do_reset();
        drive(1, 1, 0, IDLE_A, 0, 0, 8'h00);
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 1, CTRL_A, 1, 1, 8'hFF);
        tick();
        tick();
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (lfsr_step !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_step got=%b exp=0", lfsr_step);
        end
        checks++;
        if ({io_out_en, dbus_out} !== {1'b1, 8'h02}) begin
            failures++; $display("[TB] FAIL reset_status got=%h exp=102", {io_out_en, dbus_out});
        end
        tick();
        drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if ({io_out_en, dbus_out} !== {1'b1, 8'h00}) begin
            failures++; $display("[TB] FAIL empty_read got=%h exp=100", {io_out_en, dbus_out});
        end
        tick();
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h0A) begin
            failures++; $display("[TB] FAIL underflow_status got=%h exp=0a", dbus_out);
        end
        tick();
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h08);
        @(negedge clk);
        checks++;
        if (io_out_en !== 1'b0) begin
            failures++; $display("[TB] FAIL write_oen got=%b exp=0", io_out_en);
        end
        tick();
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h02) begin
            failures++; $display("[TB] FAIL uf_clear got=%h exp=02", dbus_out);
        end
        tick();
    endtask

    task automatic test_fill_and_refill();
        int         pulses;
        logic [7:0] want [4];
        do_reset();
        src_q.delete();
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        src_q.push_back(8'h44); src_q.push_back(8'h55);
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h01);
        tick();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            @(negedge clk);
            pulses += int'(lfsr_step);
            checks++;
            if ({lfsr_step, io_out_en, dbus_out} !== {exp_step(), exp_oen(), exp_dout()}) begin
                failures++; $display("[TB] FAIL fill_cycle got=%h exp=%h",
                    {lfsr_step, io_out_en, dbus_out}, {exp_step(), exp_oen(), exp_dout()});
            end
            tick();
        end
        checks++;
        if (pulses != 4) begin
            failures++; $display("[TB] FAIL fill_pulses got=%0d exp=4", pulses);
        end
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h45) begin
            failures++; $display("[TB] FAIL full_status got=%h exp=45", dbus_out);
        end
        tick();
        // One pop from a full FIFO must trigger exactly one refill
        drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== exp_dout()) begin
            failures++; $display("[TB] FAIL first_pop got=%h exp=%h", dbus_out, exp_dout());
        end
`ifndef XLR8_RNG_WHITEN_EN
        checks++;
        if (dbus_out !== 8'h11) begin
            failures++; $display("[TB] FAIL first_pop_raw got=%h exp=11", dbus_out);
        end
`endif
        tick();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            @(negedge clk);
            pulses += int'(lfsr_step);
            checks++;
            if ({lfsr_step, dbus_out} !== {exp_step(), exp_dout()}) begin
                failures++; $display("[TB] FAIL refill_cycle got=%h exp=%h",
                    {lfsr_step, dbus_out}, {exp_step(), exp_dout()});
            end
            tick();
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("[TB] FAIL refill_pulses got=%0d exp=1", pulses);
        end
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h45) begin
            failures++; $display("[TB] FAIL refull_status got=%h exp=45", dbus_out);
        end
        tick();
        want[0] = 8'h22; want[1] = 8'h33; want[2] = 8'h44; want[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
            @(negedge clk);
            checks++;
            if (dbus_out !== exp_dout()) begin
                failures++; $display("[TB] FAIL wrap_pop%0d got=%h exp=%h", i, dbus_out, exp_dout());
            end
`ifndef XLR8_RNG_WHITEN_EN
            checks++;
            if (dbus_out !== want[i]) begin
                failures++; $display("[TB] FAIL wrap_raw%0d got=%h exp=%h", i, dbus_out, want[i]);
            end
`endif
            tick();
        end
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h02) begin
            failures++; $display("[TB] FAIL drained_status got=%h exp=02", dbus_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit done;
        int pulses;
        do_reset();
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h01);
        tick();
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_pend && m_q.size() == 2) begin
                drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
                done = 1;
            end else begin
                drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            end
            @(negedge clk);
            checks++;
            if ({lfsr_step, dbus_out} !== {exp_step(), exp_dout()}) begin
                failures++; $display("[TB] FAIL b2b_cycle got=%h exp=%h",
                    {lfsr_step, dbus_out}, {exp_step(), exp_dout()});
            end
            tick();
        end
        checks++;
        if (!done) begin
            failures++; $display("[TB] FAIL b2b_timeout got=0 exp=1");
        end
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out[7:4] !== 4'd2) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d exp=2", dbus_out[7:4]);
        end
        tick();
        // Disabling while a capture is pending still completes that capture
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h00);
        @(negedge clk);
        checks++;
        if (m_pend !== 1'b1 || dbus_out !== exp_dout()) begin
            failures++; $display("[TB] FAIL disable_pending got=%h exp=%h", dbus_out, exp_dout());
        end
        tick();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
            @(negedge clk);
            pulses += int'(lfsr_step);
            tick();
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("[TB] FAIL disabled_pulses got=%0d exp=0", pulses);
        end
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (dbus_out !== 8'h30) begin
            failures++; $display("[TB] FAIL disabled_status got=%h exp=30", dbus_out);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
            @(negedge clk);
            checks++;
            if (dbus_out !== exp_dout()) begin
                failures++; $display("[TB] FAIL b2b_drain%0d got=%h exp=%h", i, dbus_out, exp_dout());
            end
            tick();
        end
    endtask

    task automatic test_midfill_reset_and_freeze();
        bit         seen;
        logic [7:0] snap;
        do_reset();
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h01);
        tick();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            @(negedge clk);
            seen = lfsr_step;
            tick();
        end
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL midfill_step_timeout got=0 exp=1");
        end
        drive(1, 1, 1, IDLE_A, 0, 0, 8'h00);
        tick();
        drive(0, 1, 1, CTRL_A, 1, 0, 8'h00);
        @(negedge clk);
        checks++;
        if ({lfsr_step, dbus_out} !== {1'b0, 8'h02}) begin
            failures++; $display("[TB] FAIL midfill_reset got=%h exp=002", {lfsr_step, dbus_out});
        end
        tick();
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h01);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            tick();
        end
        snap = exp_status();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, CTRL_A, 1, 1, 8'h08);
            @(negedge clk);
            checks++;
            if ({lfsr_step, dbus_out} !== {1'b0, snap}) begin
                failures++; $display("[TB] FAIL freeze%0d got=%h exp=%h", i, {lfsr_step, dbus_out}, {1'b0, snap});
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, (i[0] ? CTRL_A : IDLE_A), 1, 0, 8'h00);
            @(negedge clk);
            checks++;
            if ({lfsr_step, dbus_out} !== {exp_step(), exp_dout()}) begin
                failures++; $display("[TB] FAIL thaw%0d got=%h exp=%h", i,
                    {lfsr_step, dbus_out}, {exp_step(), exp_dout()});
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] adr;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       adr = CTRL_A;
                1:       adr = DATA_A;
                default: adr = 8'($urandom);
            endcase
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                  adr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom));
            @(negedge clk);
            checks++;
            if ({lfsr_step, io_out_en, dbus_out} !== {exp_step(), exp_oen(), exp_dout()}) begin
                failures++; $display("[TB] FAIL random%0d got=%h exp=%h", i,
                    {lfsr_step, io_out_en, dbus_out}, {exp_step(), exp_oen(), exp_dout()});
            end
            tick();
        end
    endtask

`ifdef XLR8_RNG_WHITEN_EN
    task automatic test_whiten();
        logic [7:0] want [2];
        do_reset();
        src_q.delete();
        src_q.push_back(8'h80);
        src_q.push_back(8'h01);
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h01);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            tick();
        end
        drive(0, 1, 1, CTRL_A, 0, 1, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, IDLE_A, 0, 0, 8'h00);
            tick();
        end
        want[0] = 8'h80;
        want[1] = 8'h41;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, DATA_A, 1, 0, 8'h00);
            @(negedge clk);
            checks++;
            if (dbus_out !== want[i]) begin
                failures++; $display("[TB] FAIL whiten%0d got=%h exp=%h", i, dbus_out, want[i]);
            end
            tick();
        end
    endtask
`endif

    // Directed scenarios first, then a randomized soak against the model
    initial begin
        clk       = 1'b0;
        checks    = 0;
        failures  = 0;
        lfsr_data = 8'h00;
        m_prev    = 8'h00;
        drive(1, 1, 0, IDLE_A, 0, 0, 8'h00);
        test_reset();
        test_fill_and_refill();
        test_back_to_back();
        test_midfill_reset_and_freeze();
`ifdef XLR8_RNG_WHITEN_EN
        test_whiten();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
